// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises a word as back-to-back UART frames behind a valid/ready handshake
module uart_word_tx #(
  parameter int CLK_DIV   = 5208,
  parameter int WORD_W    = 12,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1,
  parameter int GAP_BITS  = 1,
  localparam int NFRAMES  = (WORD_W + DATA_BITS - 1) / DATA_BITS,
  localparam int FW       = NFRAMES > 1 ? $clog2(NFRAMES) : 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              tx,
  output logic              busy,
  output logic [FW-1:0]     frame_idx
);
  localparam int SW = NFRAMES * DATA_BITS;
  localparam int CW = $clog2(CLK_DIV);
  localparam int MB = DATA_BITS > STOP_BITS ? (DATA_BITS > GAP_BITS ? DATA_BITS : GAP_BITS)
                                            : (STOP_BITS > GAP_BITS ? STOP_BITS : GAP_BITS);
  localparam int BW = $clog2(MB + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] D_LAST   = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] S_LAST   = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] G_LAST   = BW'(GAP_BITS > 0 ? GAP_BITS - 1 : 0);
  localparam logic [FW-1:0] F_LAST   = FW'(NFRAMES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, GAP} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [BW-1:0]   bidx, bidx_d;
  logic [SW-1:0]   sh, sh_d;
  logic [FW-1:0]   fidx_d;
  logic            par, par_d, tx_d, tick, last_f;

  assign tick       = cnt == CNT_LAST;
  assign last_f     = frame_idx == F_LAST;
  assign word_ready = state == IDLE;
  assign busy       = state != IDLE;

  // Registered state; tx is registered from the next-state level so the start bit appears on the accept edge
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bidx      <= '0;
      sh        <= '0;
      frame_idx <= '0;
      par       <= 1'b0;
      tx        <= 1'b1;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bidx      <= bidx_d;
      sh        <= sh_d;
      frame_idx <= fidx_d;
      par       <= par_d;
      tx        <= tx_d;
    end
  end

  // Next-state logic: bit timing, frame sequencing, shifting and running parity
  always_comb begin
    state_d = state;
    cnt_d   = (state == IDLE || tick) ? '0 : cnt + 1'b1;
    bidx_d  = bidx;
    sh_d    = sh;
    fidx_d  = frame_idx;
    par_d   = par;
    case (state)
      IDLE: if (word_valid) begin
        state_d = START;
        sh_d    = SW'(word_data);
        fidx_d  = '0;
        bidx_d  = '0;
      end
      START: if (tick) begin
        state_d = DATA;
        bidx_d  = '0;
        par_d   = 1'b0;
      end
      DATA: if (tick) begin
        sh_d    = sh >> 1;
        par_d   = par ^ sh[0];
        bidx_d  = bidx == D_LAST ? '0 : bidx + 1'b1;
        state_d = bidx != D_LAST ? DATA : PARITY != 0 ? PAR : STOP;
      end
      PAR: if (tick) begin
        state_d = STOP;
        bidx_d  = '0;
      end
      STOP: if (tick) begin
        bidx_d  = bidx == S_LAST ? '0 : bidx + 1'b1;
        state_d = bidx != S_LAST ? STOP : last_f ? IDLE : GAP_BITS > 0 ? GAP : START;
        fidx_d  = bidx != S_LAST ? frame_idx : last_f ? '0 : GAP_BITS > 0 ? frame_idx : frame_idx + 1'b1;
      end
      GAP: if (tick) begin
        bidx_d  = bidx == G_LAST ? '0 : bidx + 1'b1;
        state_d = bidx == G_LAST ? START : GAP;
        fidx_d  = bidx == G_LAST ? frame_idx + 1'b1 : frame_idx;
      end
      default: state_d = IDLE;
    endcase
    tx_d = state_d == START ? 1'b0 :
           state_d == DATA  ? sh_d[0] :
           state_d == PAR   ? (PARITY == 2 ? ~par_d : par_d) : 1'b1;
  end
endmodule
